// File: rtl/store_rmw_if.sv
// Store sequencer bus: control handshake, store operands and data memory port.
// STORE_RMW_STATS_EN adds the store/error counters to the bundle.
`timescale 1ns/1ps
interface store_rmw_if;
  logic        start;
  logic [1:0]  store_type;
  logic [31:0] addr;
  logic [31:0] b_data;
  logic [31:0] mem_rd_data;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic        wd_sel;
  logic [31:0] merged_data;
  logic        busy;
  logic        done;
  logic        misalign_err;
`ifdef STORE_RMW_STATS_EN
  logic [15:0] store_cnt;
  logic [7:0]  err_cnt;
`endif

  modport master (
    output start, store_type, addr, b_data,
    output mem_rd_data,
    input  mem_addr, mem_wr, wd_sel,
    input  merged_data, busy, done,
    input  misalign_err
`ifdef STORE_RMW_STATS_EN
    , input store_cnt, err_cnt
`endif
  );

  modport slave (
    input  start, store_type, addr, b_data,
    input  mem_rd_data,
    output mem_addr, mem_wr, wd_sel,
    output merged_data, busy, done,
    output misalign_err
`ifdef STORE_RMW_STATS_EN
    , output store_cnt, err_cnt
`endif
  );
endinterface

// File: rtl/store_rmw_ctrl.sv
// SW/SH/SB store sequencer with read-modify-write for sub-word stores.
// Define STORE_RMW_STATS_EN to add store_cnt/err_cnt statistics counters.
`timescale 1ns/1ps
module store_rmw_ctrl #(
  parameter int MEM_RD_LAT = 1
) (
  input logic       clk,
  input logic       reset_n,
  store_rmw_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam logic [1:0] ST_SW = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SB = 2'b10;
  localparam logic [2:0] LAT_LAST = 3'(MEM_RD_LAT - 1);

  state_t      state;
  logic [1:0]  addr_lo_q;
  logic [1:0]  type_q;
  logic [15:0] b_q;
  logic [2:0]  lat_q;

  logic        bad;
  logic [31:0] merge_w;
  logic        unused_ok;

  // Upper half of B only ever reaches memory through the external mux.
  assign unused_ok = ^bus.b_data[31:16];

  always_comb begin
    bad = 1'b0;
    unique case (1'b1)
      (bus.store_type == ST_SW): bad = (bus.addr[1:0] != 2'b00);
      (bus.store_type == ST_SH): bad = bus.addr[0];
      (bus.store_type == ST_SB): bad = 1'b0;
      default:                   bad = 1'b1;
    endcase
  end

  always_comb begin
    merge_w = bus.mem_rd_data;
    unique case (1'b1)
      (type_q == ST_SB): begin
        unique case (addr_lo_q)
          2'd0: merge_w[7:0]   = b_q[7:0];
          2'd1: merge_w[15:8]  = b_q[7:0];
          2'd2: merge_w[23:16] = b_q[7:0];
          2'd3: merge_w[31:24] = b_q[7:0];
          default: ;
        endcase
      end
      (type_q == ST_SH): begin
        if (addr_lo_q[1])
          merge_w[31:16] = b_q;
        else
          merge_w[15:0] = b_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      addr_lo_q        <= '0;
      type_q           <= '0;
      b_q              <= '0;
      lat_q            <= '0;
      bus.mem_addr     <= '0;
      bus.mem_wr       <= 1'b0;
      bus.wd_sel       <= 1'b0;
      bus.merged_data  <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.misalign_err <= 1'b0;
`ifdef STORE_RMW_STATS_EN
      bus.store_cnt    <= '0;
      bus.err_cnt      <= '0;
`endif
    end else begin
      bus.mem_wr       <= 1'b0;
      bus.done         <= 1'b0;
      bus.misalign_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            addr_lo_q    <= bus.addr[1:0];
            type_q       <= bus.store_type;
            b_q          <= bus.b_data[15:0];
            lat_q        <= '0;
            bus.mem_addr <= {bus.addr[31:2], 2'b00};
            bus.busy     <= 1'b1;
            if (bad) begin
              state            <= ERR;
              bus.done         <= 1'b1;
              bus.misalign_err <= 1'b1;
            end else if (bus.store_type == ST_SW) begin
              state      <= WRITE;
              bus.mem_wr <= 1'b1;
              bus.wd_sel <= 1'b0;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (lat_q == LAT_LAST) begin
            state           <= WRITE;
            bus.merged_data <= merge_w;
            bus.mem_wr      <= 1'b1;
            bus.wd_sel      <= 1'b1;
          end else begin
            lat_q <= lat_q + 3'd1;
          end
        end
        WRITE: begin
          state    <= DONE;
          bus.done <= 1'b1;
`ifdef STORE_RMW_STATS_EN
          bus.store_cnt <= bus.store_cnt + 16'd1;
`endif
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        ERR: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
`ifdef STORE_RMW_STATS_EN
          bus.err_cnt <= bus.err_cnt + 8'd1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Scoreboard bench: one controller at read latency 1, one at latency 3.
// Both see the same stimulus; expectations are queued per instance.
`timescale 1ns/1ps
module tb_store_rmw_ctrl;

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic        wd;
    logic [31:0] m;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [1:0]  stype = '0;
  logic [31:0] addr  = '0;
  logic [31:0] bdat  = '0;
  logic [31:0] rdat  = '0;

  store_rmw_if ia();
  store_rmw_if ib();

  assign ia.start = start;       assign ib.start = start;
  assign ia.store_type = stype;  assign ib.store_type = stype;
  assign ia.addr = addr;         assign ib.addr = addr;
  assign ia.b_data = bdat;       assign ib.b_data = bdat;
  assign ia.mem_rd_data = rdat;  assign ib.mem_rd_data = rdat;

  store_rmw_ctrl #(.MEM_RD_LAT(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ia.slave));
  store_rmw_ctrl #(.MEM_RD_LAT(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ib.slave));

  logic        mw[2], wd[2], dn[2], me[2], bz[2];
  logic [31:0] ma[2], md[2];
  assign mw[0] = ia.mem_wr;       assign mw[1] = ib.mem_wr;
  assign wd[0] = ia.wd_sel;       assign wd[1] = ib.wd_sel;
  assign dn[0] = ia.done;         assign dn[1] = ib.done;
  assign me[0] = ia.misalign_err; assign me[1] = ib.misalign_err;
  assign bz[0] = ia.busy;         assign bz[1] = ib.busy;
  assign ma[0] = ia.mem_addr;     assign ma[1] = ib.mem_addr;
  assign md[0] = ia.merged_data;  assign md[1] = ib.merged_data;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int exp_st = 0;
  int exp_er = 0;
  exp_t wq[2][$];
  exp_t dq[2][$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %08h want %08h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      for (int k = 0; k < 2; k++) begin
        if (mw[k]) begin
          if (wq[k].size() == 0) begin
            chk($sformatf("u%0d wr_unexp", k), 1, 0);
          end else begin
            e = wq[k].pop_front();
            chk($sformatf("u%0d wr_cyc", k), cyc, e.cyc);
            chk($sformatf("u%0d wr_addr", k), ma[k], e.a);
            chk($sformatf("u%0d wr_wdsel", k), 32'(wd[k]), 32'(e.wd));
            if (e.wd)
              chk($sformatf("u%0d merged", k), md[k], e.m);
          end
        end
        if (dn[k]) begin
          if (dq[k].size() == 0) begin
            chk($sformatf("u%0d done_unexp", k), 1, 0);
          end else begin
            e = dq[k].pop_front();
            chk($sformatf("u%0d done_cyc", k), cyc, e.cyc);
            chk($sformatf("u%0d done_err", k), 32'(me[k]), 32'(e.err));
            chk($sformatf("u%0d done_busy", k), 32'(bz[k]), 1);
            if (!e.err) begin
              chk($sformatf("u%0d done_addr", k), ma[k], e.a);
              chk($sformatf("u%0d done_wdsel", k), 32'(wd[k]), 32'(e.wd));
            end
          end
        end
        if (me[k] && !dn[k])
          chk($sformatf("u%0d err_nodone", k), 0, 1);
      end
    end
  end

  task automatic chk_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s u%0d outs", tag, k),
          {26'd0, mw[k], wd[k], dn[k], me[k], bz[k], 1'b0}, 0);
      chk($sformatf("%s u%0d mem_addr", tag, k), ma[k], 0);
      chk($sformatf("%s u%0d merged", tag, k), md[k], 0);
    end
  endtask

  task automatic chk_stats(input string tag);
`ifdef STORE_RMW_STATS_EN
    chk({tag, " u0 store_cnt"}, 32'(ia.store_cnt), 32'(exp_st[15:0]));
    chk({tag, " u1 store_cnt"}, 32'(ib.store_cnt), 32'(exp_st[15:0]));
    chk({tag, " u0 err_cnt"}, 32'(ia.err_cnt), 32'(exp_er[7:0]));
    chk({tag, " u1 err_cnt"}, 32'(ib.err_cnt), 32'(exp_er[7:0]));
`else
    if (tag.len() == 0) $display("stats disabled");
`endif
  endtask

  // Issues one start pulse at a negedge and queues the expected outcome.
  task automatic op(input logic [1:0] t, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] rd);
    int   sc;
    int   wc;
    logic err;
    logic [31:0] m;
    exp_t e;
    sc = cyc;
    stype = t; addr = a; bdat = b; rdat = rd; start = 1'b1;
    err = (t == 2'b11) || (t == 2'b00 && a[1:0] != 2'b00) ||
          (t == 2'b01 && a[0]);
    m = rd;
    if (t == 2'b10) m[8*a[1:0] +: 8] = b[7:0];
    if (t == 2'b01) m[16*a[1] +: 16] = b[15:0];
    if (err) exp_er++;
    else exp_st++;
    for (int k = 0; k < 2; k++) begin
      e.a = {a[31:2], 2'b00};
      e.wd = (t != 2'b00);
      e.m = m;
      e.err = err;
      if (err) begin
        e.cyc = sc + 1;
        dq[k].push_back(e);
      end else begin
        wc = (t == 2'b00) ? sc + 1 : sc + (k == 0 ? 1 : 3) + 1;
        e.cyc = wc;
        wq[k].push_back(e);
        e.cyc = wc + 1;
        dq[k].push_back(e);
      end
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!bz[0] && !bz[1]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, " idle"}, 32'(ok), 1);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s u%0d wq_empty", tag, k), wq[k].size(), 0);
      chk($sformatf("%s u%0d dq_empty", tag, k), dq[k].size(), 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  t;
    repeat (2) @(negedge clk);
    chk_zero("rst_hold");
    reset_n = 1'b1;
    @(negedge clk);
    chk_zero("rst_rel");
    chk_stats("rst");

    op(2'b00, 32'h10, 32'hDEADBEEF, 32'h0);
    wait_idle("sw");
    op(2'b10, 32'h13, 32'h000000AA, 32'h11223344);
    wait_idle("sb");
    op(2'b01, 32'h22, 32'h0000BEEF, 32'h11223344);
    wait_idle("sh");

    op(2'b00, 32'h11, 32'h1, 32'h0);
    wait_idle("sw_mis");
    op(2'b01, 32'h21, 32'h2, 32'h0);
    wait_idle("sh_mis");
    op(2'b11, 32'h40, 32'h3, 32'h0);
    wait_idle("bad_type");
    chk_stats("mid");

    for (int i = 0; i < 4; i++) begin
      op(2'b10, 32'h100 + 32'(i), 32'h5A5A5A00 | 32'(i),
         32'hCAFEF00D);
      wait_idle("sb_lane");
    end
    op(2'b01, 32'h200, 32'hFFFF1234, 32'h89ABCDEF);
    wait_idle("sh_lo");
    for (int i = 0; i < 8; i++) begin
      t = 2'($urandom_range(0, 3));
      a = $urandom;
      op(t, a, $urandom, $urandom);
      wait_idle("rand");
    end

    // Extra start pulses during READ and in the LAT=1 unit's DONE cycle.
    op(2'b10, 32'h31, 32'h000000C3, 32'h01020304);
    start = 1'b1; stype = 2'b00; addr = 32'h50; bdat = 32'h12345678;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("ignored_start");

    // Reset while both units are reading: no write may follow.
    op(2'b01, 32'h62, 32'h00001234, 32'hAABBCCDD);
    reset_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    for (int k = 0; k < 2; k++) begin
      wq[k].delete();
      dq[k].delete();
    end
    exp_st = 0;
    exp_er = 0;
    chk_stats("rst_mid");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    chk_zero("post_rst");

    op(2'b00, 32'h84, 32'h0BADF00D, 32'h0);
    wait_idle("sw_after");
    op(2'b10, 32'h86, 32'h77, 32'hFFFFFFFF);
    wait_idle("sb_after");
    op(2'b11, 32'h0, 32'h0, 32'h0);
    wait_idle("err_after");
    chk_stats("final");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
